// File: rtl/lock_controller.sv
// ---------------------------------------------------------------------------
// lock_controller
// Canal lock sequencer: two gates (low-side "outer", high-side "inner") and
// a chamber that is filled or drained one level step per clock. All outputs
// are Moore, decoded from the registered state and level.
//
// Optional feature: define LOCK_BOAT_COUNT_EN to add the boats_passed
// output, a saturating count of INNER_OPEN -> HIGH_CLOSED transitions.
// ---------------------------------------------------------------------------
module lock_controller #(
    parameter int LEVEL_MAX = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       arrival,
    input  logic       departure,
    input  logic       outer_gate_sw,
    input  logic       inner_gate_sw,
    input  logic       raise_sw,
    input  logic       lower_sw,
`ifdef LOCK_BOAT_COUNT_EN
    output logic [7:0] boats_passed,
`endif
    output logic       outer_open,
    output logic       inner_open,
    output logic       filling,
    output logic       draining,
    output logic [7:0] level,
    output logic [2:0] state
);

    localparam logic [2:0] ST_LOW_CLOSED  = 3'd0;
    localparam logic [2:0] ST_OUTER_OPEN  = 3'd1;
    localparam logic [2:0] ST_FILLING     = 3'd2;
    localparam logic [2:0] ST_HIGH_CLOSED = 3'd3;
    localparam logic [2:0] ST_INNER_OPEN  = 3'd4;
    localparam logic [2:0] ST_DRAINING    = 3'd5;

    localparam logic [7:0] LMAX = 8'(LEVEL_MAX);

    logic [2:0] state_q;
    logic [2:0] state_d;
    logic [7:0] level_q;
    logic [7:0] level_d;
    logic       raise_s;
    logic       lower_s;

    // State and level registers; reset aborts any pending fill/drain step.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_LOW_CLOSED;
            level_q <= 8'd0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
        end
    end

    // Next-state and next-level logic; raise and lower together cancel out.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        raise_s = raise_sw & ~lower_sw;
        lower_s = lower_sw & ~raise_sw;
        case (state_q)
            ST_LOW_CLOSED: begin
                if (arrival && outer_gate_sw) begin
                    state_d = ST_OUTER_OPEN;
                end else if (raise_s) begin
                    state_d = ST_FILLING;
                end else begin
                    state_d = ST_LOW_CLOSED;
                end
            end
            ST_OUTER_OPEN: begin
                if (!outer_gate_sw) begin
                    state_d = ST_LOW_CLOSED;
                end else begin
                    state_d = ST_OUTER_OPEN;
                end
            end
            ST_FILLING: begin
                if (lower_s) begin
                    // Reverse without touching the level on this edge.
                    state_d = ST_DRAINING;
                end else if (level_q >= LMAX) begin
                    // Already full (entered by reversal at the top): no wrap.
                    state_d = ST_HIGH_CLOSED;
                end else begin
                    level_d = level_q + 8'd1;
                    if ((level_q + 8'd1) == LMAX) begin
                        state_d = ST_HIGH_CLOSED;
                    end else begin
                        state_d = ST_FILLING;
                    end
                end
            end
            ST_HIGH_CLOSED: begin
                if (departure && inner_gate_sw) begin
                    state_d = ST_INNER_OPEN;
                end else if (lower_s) begin
                    state_d = ST_DRAINING;
                end else begin
                    state_d = ST_HIGH_CLOSED;
                end
            end
            ST_INNER_OPEN: begin
                if (!inner_gate_sw) begin
                    state_d = ST_HIGH_CLOSED;
                end else begin
                    state_d = ST_INNER_OPEN;
                end
            end
            ST_DRAINING: begin
                if (raise_s) begin
                    state_d = ST_FILLING;
                end else if (level_q == 8'd0) begin
                    // Already empty (entered by reversal at the bottom): no wrap.
                    state_d = ST_LOW_CLOSED;
                end else begin
                    level_d = level_q - 8'd1;
                    if (level_q == 8'd1) begin
                        state_d = ST_LOW_CLOSED;
                    end else begin
                        state_d = ST_DRAINING;
                    end
                end
            end
            default: begin
                // Unused codes recover to a known empty, closed lock.
                state_d = ST_LOW_CLOSED;
                level_d = 8'd0;
            end
        endcase
    end

    // Moore output decode from the registered state and level.
    always_comb begin
        outer_open = 1'b0;
        inner_open = 1'b0;
        filling    = 1'b0;
        draining   = 1'b0;
        case (state_q)
            ST_OUTER_OPEN: outer_open = 1'b1;
            ST_INNER_OPEN: inner_open = 1'b1;
            ST_FILLING:    filling    = 1'b1;
            ST_DRAINING:   draining   = 1'b1;
            default: begin
                outer_open = 1'b0;
                inner_open = 1'b0;
                filling    = 1'b0;
                draining   = 1'b0;
            end
        endcase
        level = level_q;
        state = state_q;
    end

`ifdef LOCK_BOAT_COUNT_EN
    logic [7:0] boats_q;
    logic [7:0] boats_d;

    // Next boat count: one per inner gate closing, saturating at 255.
    always_comb begin
        boats_d = boats_q;
        if ((state_q == ST_INNER_OPEN) && (state_d == ST_HIGH_CLOSED) && (boats_q != 8'd255)) begin
            boats_d = boats_q + 8'd1;
        end else begin
            boats_d = boats_q;
        end
    end

    // Boat counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            boats_q <= 8'd0;
        end else begin
            boats_q <= boats_d;
        end
    end

    assign boats_passed = boats_q;
`endif

endmodule
